// File: rtl/fsm_trace_decoder_pkg.sv
// fsm_trace_pkg: shared definitions for the sequence-FSM trace decoder.
//   - Moore state codes of the traced 5-state FSM (Q0..Q4)
//   - monitor state encoding (HUNT / SYNC / LOCKED)
//   - idx_of_code(): state index 0..4 for a legal code, IDX_NONE otherwise
package fsm_trace_pkg;

  localparam logic [2:0] Q0 = 3'd2;
  localparam logic [2:0] Q1 = 3'd6;
  localparam logic [2:0] Q2 = 3'd4;
  localparam logic [2:0] Q3 = 3'd7;
  localparam logic [2:0] Q4 = 3'd1;

  localparam logic [2:0] IDX_NONE = 3'd7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  function automatic logic [2:0] idx_of_code(input logic [2:0] code);
    case (code)
      Q0:      return 3'd0;
      Q1:      return 3'd1;
      Q2:      return 3'd2;
      Q3:      return 3'd3;
      Q4:      return 3'd4;
      default: return IDX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fsm_trace_decoder_if.sv
// fsm_trace_decoder_if: trace bus between an FSM code source and the decoder.
//   code_in/code_vld       : sampled state code stream (source -> decoder)
//   a_out/a_vld/a_known    : recovered input bit and its qualifiers
//   err/locked/err_count   : error pulse, lock status, saturating error count
//   cur_idx                : index of last accepted state, 7 when none
// master = code source, slave = decoder.
interface fsm_trace_decoder_if #(parameter int CNT_W = 8);

  logic [2:0]       code_in;
  logic             code_vld;
  logic             a_out;
  logic             a_vld;
  logic             a_known;
  logic             err;
  logic             locked;
  logic [CNT_W-1:0] err_count;
  logic [2:0]       cur_idx;

  modport master (
    output code_in, code_vld,
    input  a_out, a_vld, a_known, err, locked, err_count, cur_idx
  );

  modport slave (
    input  code_in, code_vld,
    output a_out, a_vld, a_known, err, locked, err_count, cur_idx
  );

endinterface

// File: rtl/fsm_trace_decoder_lut.sv
// fsm_trans_lut: combinational transition table of the traced FSM.
//   prev, next  : previous and current state codes
//   legal_code  : next is one of the five state codes
//   legal_trans : prev -> next is an edge of the FSM
//   a_bit       : input bit that selects this edge (valid when a_dep)
//   a_dep       : edge depends on the input bit (0 = unconditional edge)
module fsm_trans_lut
  import fsm_trace_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] next,
  output logic       legal_code,
  output logic       legal_trans,
  output logic       a_bit,
  output logic       a_dep
);

  assign legal_code = (idx_of_code(next) != IDX_NONE);

  always_comb begin
    legal_trans = 1'b0;
    a_bit       = 1'b0;
    a_dep       = 1'b0;
    case ({prev, next})
      {Q0, Q2}, {Q1, Q3}, {Q4, Q1}: legal_trans = 1'b1;
      {Q2, Q1}, {Q3, Q0}: begin
        legal_trans = 1'b1;
        a_dep       = 1'b1;
      end
      {Q2, Q4}, {Q3, Q2}: begin
        legal_trans = 1'b1;
        a_bit       = 1'b1;
        a_dep       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm_trace_decoder.sv
// fsm_trace_decoder: checks a 3-bit Moore state-code stream against the
// FSM transition table and recovers the input bit driving each step.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : fsm_trace_decoder_if.slave (code stream in, decode/status out)
// All outputs are registered; results for a sample appear one clock later.
module fsm_trace_decoder
  import fsm_trace_pkg::*;
#(
  parameter int LOCK_LEN = 2,
  parameter int CNT_W    = 8
) (
  input logic                clk,
  input logic                reset,
  fsm_trace_decoder_if.slave bus
);

  localparam logic [2:0] LOCK_LEN_C = 3'(LOCK_LEN);

  mon_state_t       state;
  logic [2:0]       prev_code;
  logic [2:0]       run;
  logic [2:0]       cur_idx_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             a_out_q, a_vld_q, a_known_q, err_q, locked_q;

  logic             legal_code, legal_trans, a_bit, a_dep;
  logic             err_now;
  logic [2:0]       run_inc;

  fsm_trans_lut u_lut (
    .prev        (prev_code),
    .next        (bus.code_in),
    .legal_code  (legal_code),
    .legal_trans (legal_trans),
    .a_bit       (a_bit),
    .a_dep       (a_dep)
  );

  // In HUNT there is no valid history, so only the code itself can be wrong.
  assign err_now = bus.code_vld && (!legal_code || (state != HUNT && !legal_trans));
  assign run_inc = run + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      prev_code <= 3'd0;
      run       <= 3'd0;
      cur_idx_q <= IDX_NONE;
      err_cnt_q <= '0;
      a_out_q   <= 1'b0;
      a_vld_q   <= 1'b0;
      a_known_q <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      a_vld_q <= 1'b0;
      err_q   <= err_now;
      if (err_now && !(&err_cnt_q))
        err_cnt_q <= err_cnt_q + 1'b1;

      if (bus.code_vld) begin
        if (!legal_code) begin
          state    <= HUNT;
          locked_q <= 1'b0;
        end else begin
          prev_code <= bus.code_in;
          cur_idx_q <= idx_of_code(bus.code_in);
          case (state)
            HUNT: begin
              state <= SYNC;
              run   <= 3'd0;
            end
            SYNC, LOCKED: begin
              if (legal_trans) begin
                a_vld_q   <= 1'b1;
                a_out_q   <= a_bit;
                a_known_q <= a_dep;
                if (state == SYNC) begin
                  run <= run_inc;
                  if (run_inc == LOCK_LEN_C) begin
                    state    <= LOCKED;
                    locked_q <= 1'b1;
                  end
                end
              end else begin
                // Bad edge but a real code: resync from this code.
                state    <= SYNC;
                locked_q <= 1'b0;
                run      <= 3'd0;
              end
            end
            default: begin
              state    <= HUNT;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.a_vld     = a_vld_q;
  assign bus.a_known   = a_known_q;
  assign bus.err       = err_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = err_cnt_q;
  assign bus.cur_idx   = cur_idx_q;

endmodule

// File: tb/tb_fsm_trace_decoder.sv
// Bench for fsm_trace_decoder: two instances (err_count 8 bits and 2 bits)
// driven with the same stream and compared against a table-driven model.
module tb_fsm_trace_decoder;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fsm_trace_decoder_if #(.CNT_W(8)) bus8 ();
  fsm_trace_decoder_if #(.CNT_W(2)) bus2 ();

  fsm_trace_decoder #(.LOCK_LEN(2), .CNT_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  fsm_trace_decoder #(.LOCK_LEN(2), .CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int LOCK_LEN = 2;
  int qc[5] = '{2, 6, 4, 7, 1};
  int tp[7] = '{2, 6, 1, 4, 4, 7, 7};
  int tn[7] = '{4, 7, 6, 6, 1, 2, 4};
  int ta[7] = '{0, 0, 0, 0, 1, 0, 1};
  int tk[7] = '{0, 0, 0, 1, 1, 1, 1};

  string m_mode;
  int    m_prev, m_run, m_cur, m_errs;
  bit    m_a_out, m_a_vld, m_a_known, m_err;

  function automatic int code_idx(int c);
    for (int i = 0; i < 5; i++) if (qc[i] == c) return i;
    return 7;
  endfunction

  function automatic int find_edge(int p, int n);
    for (int i = 0; i < 7; i++) if (tp[i] == p && tn[i] == n) return i;
    return -1;
  endfunction

  task automatic model_update(input bit rst, input bit vld, input int code);
    int e;
    if (rst) begin
      m_mode = "HUNT"; m_prev = 0; m_run = 0; m_cur = 7; m_errs = 0;
      m_a_out = 0; m_a_vld = 0; m_a_known = 0; m_err = 0;
      return;
    end
    m_a_vld = 0;
    m_err   = 0;
    if (!vld) return;
    if (code_idx(code) == 7) begin
      m_err  = 1;
      m_mode = "HUNT";
    end else if (m_mode == "HUNT") begin
      m_prev = code; m_cur = code_idx(code); m_run = 0; m_mode = "SYNC";
    end else begin
      e = find_edge(m_prev, code);
      m_prev = code;
      m_cur  = code_idx(code);
      if (e >= 0) begin
        m_a_vld = 1; m_a_out = ta[e][0]; m_a_known = tk[e][0];
        if (m_mode == "SYNC") begin
          m_run++;
          if (m_run >= LOCK_LEN) m_mode = "LOCKED";
        end
      end else begin
        m_err = 1; m_run = 0; m_mode = "SYNC";
      end
    end
    if (m_err) m_errs++;
  endtask

  function automatic logic [15:0] exp8();
    int c;
    c = (m_errs > 255) ? 255 : m_errs;
    return {m_a_out, m_a_vld, m_a_known, m_err, m_mode == "LOCKED", 3'(m_cur), 8'(c)};
  endfunction

  function automatic logic [9:0] exp2();
    int c;
    c = (m_errs > 3) ? 3 : m_errs;
    return {m_a_out, m_a_vld, m_a_known, m_err, m_mode == "LOCKED", 3'(m_cur), 2'(c)};
  endfunction

  function automatic logic [15:0] obs8();
    return {bus8.a_out, bus8.a_vld, bus8.a_known, bus8.err, bus8.locked, bus8.cur_idx, bus8.err_count};
  endfunction

  function automatic logic [9:0] obs2();
    return {bus2.a_out, bus2.a_vld, bus2.a_known, bus2.err, bus2.locked, bus2.cur_idx, bus2.err_count};
  endfunction

  // drive one sample, let the edge happen, advance the model
  task automatic step(input bit rst, input bit vld, input int code);
    reset         = rst;
    bus8.code_vld = vld;
    bus2.code_vld = vld;
    bus8.code_in  = 3'(code);
    bus2.code_in  = 3'(code);
    @(posedge clk);
    #1;
    model_update(rst, vld, code);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1, 0, 0);
    step(1, 1, 2);
    checks++;
    if (obs8() !== {5'b0, 3'd7, 8'd0} || obs2() !== {5'b0, 3'd7, 2'd0}) begin
      errors++;
      $display("FAIL reset_state dut8=%h dut2=%h want8=%h", obs8(), obs2(), {5'b0, 3'd7, 8'd0});
    end
  endtask

  task automatic test_lock_sequence();
    int seq[10] = '{2, 4, 6, 7, 2, 4, 1, 6, 7, 4};
    int pulses = 0;
    int dec[$];
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, seq[i]);
      checks++;
      if (obs8() !== exp8() || obs2() !== exp2()) begin
        errors++;
        $display("FAIL lock_seq_model step %0d dut8=%h exp8=%h dut2=%h exp2=%h", i, obs8(), exp8(), obs2(), exp2());
      end
      checks++;
      if (bus8.locked !== (i >= 2) || bus8.err !== 1'b0) begin
        errors++;
        $display("FAIL lock_seq_locked step %0d locked=%b err=%b want locked=%b err=0", i, bus8.locked, bus8.err, i >= 2);
      end
      if (bus8.a_vld === 1'b1) begin
        pulses++;
        if (bus8.a_known === 1'b1) dec.push_back(int'(bus8.a_out));
      end
    end
    checks++;
    if (pulses != 9 || dec.size() != 4) begin
      errors++;
      $display("FAIL lock_seq_pulses a_vld=%0d known=%0d want 9 and 4", pulses, dec.size());
    end else begin
      checks++;
      if (dec[0] != 0 || dec[1] != 0 || dec[2] != 1 || dec[3] != 1) begin
        errors++;
        $display("FAIL lock_seq_decode got %0d%0d%0d%0d want 0011", dec[0], dec[1], dec[2], dec[3]);
      end
    end
    checks++;
    if (bus8.err_count !== 8'd0) begin
      errors++;
      $display("FAIL lock_seq_errcnt got %0d want 0", bus8.err_count);
    end
  endtask

  task automatic test_relock();
    int seq[6] = '{6, 7, 6, 7, 2, 4};
    for (int i = 0; i < 6; i++) begin
      step(0, 1, seq[i]);
      checks++;
      if (obs8() !== exp8() || obs2() !== exp2()) begin
        errors++;
        $display("FAIL relock_model step %0d dut8=%h exp8=%h dut2=%h exp2=%h", i, obs8(), exp8(), obs2(), exp2());
      end
      if (i == 2) begin
        checks++;
        if (bus8.err !== 1'b1 || bus8.locked !== 1'b0 || bus8.a_vld !== 1'b0) begin
          errors++;
          $display("FAIL relock_err err=%b locked=%b a_vld=%b want 1 0 0", bus8.err, bus8.locked, bus8.a_vld);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus8.locked !== 1'b1) begin
          errors++;
          $display("FAIL relock_lock locked=%b want 1", bus8.locked);
        end
      end
    end
    checks++;
    if (bus8.err_count !== 8'd1) begin
      errors++;
      $display("FAIL relock_errcnt got %0d want 1", bus8.err_count);
    end
  endtask

  task automatic test_illegal_code();
    step(0, 1, 3);
    checks++;
    if (bus8.err !== 1'b1 || bus8.locked !== 1'b0 || bus8.cur_idx !== 3'd2 || obs8() !== exp8()) begin
      errors++;
      $display("FAIL illegal_code err=%b locked=%b cur_idx=%0d want 1 0 2", bus8.err, bus8.locked, bus8.cur_idx);
    end
    step(0, 1, 2);
    checks++;
    if (bus8.a_vld !== 1'b0 || bus8.err !== 1'b0 || bus8.cur_idx !== 3'd0 || obs8() !== exp8()) begin
      errors++;
      $display("FAIL illegal_resync a_vld=%b err=%b cur_idx=%0d want 0 0 0", bus8.a_vld, bus8.err, bus8.cur_idx);
    end
    step(0, 1, 4);
    checks++;
    if (bus8.a_vld !== 1'b1 || bus8.a_known !== 1'b0 || obs8() !== exp8()) begin
      errors++;
      $display("FAIL illegal_first_edge a_vld=%b a_known=%b want 1 0", bus8.a_vld, bus8.a_known);
    end
  endtask

  task automatic test_gap();
    step(1, 0, 0);
    step(0, 1, 2);
    step(0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      checks++;
      if (bus8.a_vld !== 1'b0 || bus8.err !== 1'b0 || obs8() !== exp8()) begin
        errors++;
        $display("FAIL gap_idle cycle %0d dut8=%h exp8=%h", i, obs8(), exp8());
      end
    end
    step(0, 1, 6);
    checks++;
    if (bus8.a_vld !== 1'b1 || bus8.a_out !== 1'b0 || bus8.a_known !== 1'b1 || bus8.err !== 1'b0) begin
      errors++;
      $display("FAIL gap_decode a_vld=%b a_out=%b a_known=%b err=%b want 1 0 1 0",
               bus8.a_vld, bus8.a_out, bus8.a_known, bus8.err);
    end
  endtask

  task automatic test_saturation();
    int want2[6] = '{1, 2, 3, 3, 3, 3};
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      checks++;
      if (bus2.err !== 1'b1 || int'(bus2.err_count) != want2[i] || int'(bus8.err_count) != i + 1) begin
        errors++;
        $display("FAIL saturation step %0d err=%b cnt2=%0d cnt8=%0d want 1 %0d %0d",
                 i, bus2.err, bus2.err_count, bus8.err_count, want2[i], i + 1);
      end
    end
  endtask

  task automatic test_reset_priority();
    step(1, 0, 0);
    step(0, 1, 2);
    step(0, 1, 4);
    step(0, 1, 0);
    step(0, 1, 6);
    step(0, 1, 7);
    step(0, 1, 2);
    checks++;
    if (bus8.locked !== 1'b1 || bus8.err_count !== 8'd1) begin
      errors++;
      $display("FAIL rstprio_setup locked=%b err_count=%0d want 1 1", bus8.locked, bus8.err_count);
    end
    step(1, 1, 4);
    checks++;
    if (obs8() !== {5'b0, 3'd7, 8'd0} || obs2() !== {5'b0, 3'd7, 2'd0}) begin
      errors++;
      $display("FAIL rstprio_state dut8=%h dut2=%h want8=%h", obs8(), obs2(), {5'b0, 3'd7, 8'd0});
    end
  endtask

  task automatic test_random();
    int code, r;
    int succ[$];
    bit rst, vld;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      vld = ($urandom_range(0, 3) != 0);
      succ.delete();
      for (int i = 0; i < 7; i++) if (tp[i] == m_prev) succ.push_back(tn[i]);
      r = $urandom_range(0, 9);
      if (r < 7 && succ.size() > 0) code = succ[$urandom_range(0, succ.size() - 1)];
      else code = $urandom_range(0, 7);
      step(rst, vld, code);
      checks++;
      if (obs8() !== exp8() || obs2() !== exp2()) begin
        errors++;
        $display("FAIL random step %0d code=%0d vld=%b rst=%b dut8=%h exp8=%h dut2=%h exp2=%h",
                 n, code, vld, rst, obs8(), exp8(), obs2(), exp2());
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus8.code_vld = 1'b0;
    bus2.code_vld = 1'b0;
    bus8.code_in  = 3'd0;
    bus2.code_in  = 3'd0;
    model_update(1, 0, 0);
    test_reset();
    test_lock_sequence();
    test_relock();
    test_illegal_code();
    test_gap();
    test_saturation();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_trace_decoder.md
Name: fsm_trace_decoder

Overview:
- Decoder for the 3-bit Moore state-code stream produced by the team's 5-state sequence FSM.
- Codes are q0=2, q1=6, q2=4, q3=7 and q4=1.
- Samples the code stream, checks each step against the transition table and recovers the input bit `a` where it can be determined.
- Flags illegal codes and illegal transitions, keeps a saturating error count, and reports lock status.
- Sits on the FSM output bus as a trace checker/decoder for bench and on-chip monitoring.

Parameters:
- LOCK_LEN, 2: consecutive legal transitions needed in SYNC before `locked` asserts (range 1..7).
- CNT_W, 8: width of `err_count`.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- code_in  input  3  state code observed on the FSM output.
- code_vld  input  1  code_in is sampled on this cycle.
- a_out  output  1  recovered input bit for the last transition.
- a_vld  output  1  one-cycle pulse: a_out is meaningful.
- a_known  output  1  with a_vld: 1 means the transition depended on `a`; 0 means don't-care.
- err  output  1  one-cycle pulse: illegal code or illegal transition.
- locked  output  1  monitor is in the LOCKED state.
- err_count  output  CNT_W  saturating count of err pulses.
- cur_idx  output  3  index 0..4 of the last accepted state; 7 when none.

Behaviour:
Reset, synchronous and active-high, sampled on the rising edge of clk:
- state goes to HUNT, the previous-code register is cleared, and the run counter is set to 0.
- All outputs go to 0, except cur_idx=7.
- Reset has priority over code_vld on the same edge.
- Reset mid-stream discards all history.

Code and transition rules:
- Legal codes are {2,6,4,7,1}; codes 0, 3 and 5 are illegal.
- Transition table (prev -> next, recovered a):
  - 2->4: a known=0.
  - 6->7: a known=0.
  - 1->6: a known=0.
  - 4->6: a=0, known=1.
  - 4->1: a=1, known=1.
  - 7->2: a=0, known=1.
  - 7->4: a=1, known=1.
- Every other pair of legal codes is an illegal transition.
- A repeated code (e.g. 4->4) is illegal.

Monitor states:
- HUNT:
  - code_vld with a legal code: store it as prev, go to SYNC, run=0, no err.
  - code_vld with an illegal code: err=1, stay in HUNT.
- SYNC:
  - Legal transition: a_vld=1 (a_out/a_known per table), prev<=code, run+1.
  - When run reaches LOCK_LEN, go to LOCKED.
  - Illegal transition with a legal code: err=1, prev<=code, run=0, stay in SYNC.
  - Illegal code: err=1, go to HUNT.
- LOCKED:
  - Legal transition: a_vld=1, prev<=code.
  - Illegal transition with a legal code: err=1, prev<=code, run=0, go to SYNC.
  - Illegal code: err=1, go to HUNT.

Timing and counters:
- All outputs are registered.
- Latency is exactly 1 clock: outputs for the sample taken at edge N are visible after edge N.
- a_vld and err are pulses, never high together, and low on cycles without code_vld.
- a_out and a_known hold their last value when a_vld=0.
- locked is registered and follows the state.
- err_count increments by 1 per err and saturates at all-ones, with no wrap.
- cur_idx is updated on every accepted legal code.
- code_vld=0 cycles are ignored; history is kept across gaps of any length.

Decomposition:
- Shared package fsm_trace_pkg:
  - code constants Q0=3'd2, Q1=3'd6, Q2=3'd4, Q3=3'd7, Q4=3'd1;
  - monitor-state encoding HUNT/SYNC/LOCKED;
  - the idx-of-code mapping (2->0, 6->1, 4->2, 7->3, 1->4, else 7).
- Sub-module fsm_trans_lut, purely combinational:
  - inputs prev[2:0] and next[2:0];
  - outputs legal_code, legal_trans, a_bit and a_dep.
  - Unit-testable in isolation over all 64 pairs.

Test Plan:
1. Reset, then feed 2,4,6,7,2,4,1,6,7,4 with code_vld=1:
   - no err;
   - locked rises after the third sample (LOCK_LEN=2);
   - a_vld pulses 9 times;
   - known transitions decode 4->6 a=0, 7->2 a=0, 4->1 a=1, 7->4 a=1;
   - err_count=0.
2. While locked, feed 6,7,6:
   - the second 6 gives err=1, locked=0, SYNC;
   - following 7,2,4 relock;
   - err_count=1.
3. Feed an illegal code 3 mid-stream:
   - err=1 and HUNT;
   - cur_idx holds the last legal index;
   - next legal code 2 goes to SYNC with no a_vld;
   - then 4 gives a_vld with a_known=0.
4. Gaps: feed 4, then 5 cycles of code_vld=0 with code_in=0, then 6:
   - a_vld=1, a_out=0, a_known=1, no err.
5. Saturation with CNT_W=2: feed 0 six times in HUNT:
   - err pulses 6 times;
   - err_count goes 1,2,3,3,3,3.
6. Assert reset on the same edge as code_vld=1 with code 4 while locked:
   - next cycle shows HUNT, locked=0, err_count=0, cur_idx=7, a_vld=0.
